theta_slice_engine: RTL and testbench

- Slice-serial, parametrised theta (column-parity mix) stage for the matrix encoder datapath.
- Accepts a full state of LANE_W 25-bit slices, one slice per handshake, and buffers it with per-slice 5-bit column parities.
- Then emits LANE_W mixed slices, handling the slice-0 wrap-around internally.
- Sits between the state loader and the downstream rho/pi stages. Ready/valid on both sides.

---
 rtl/theta_slice_engine.sv | 125 ++++++++++++
 tb/tb_theta_slice_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/theta_slice_engine.sv
// Slice-serial theta stage: buffers LANE_W 25-bit slices with column parities, then emits mixed slices.
// Optional macro THETA_BYPASS_EN adds a bypass input that passes slices through unmixed.
module theta_slice_engine #(
    parameter int unsigned LANE_W  = 64,
    parameter int unsigned SLICE_W = 25
) (
`ifdef THETA_BYPASS_EN
    input  logic               bypass,
`endif
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SLICE_W-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [SLICE_W-1:0] m_data,
    output logic               m_last,
    output logic               busy
);

    localparam int unsigned   CW   = $clog2(LANE_W);
    localparam logic [CW-1:0] LAST = CW'(LANE_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      nxt;
    logic [SLICE_W-1:0] a_mem [LANE_W];
    logic [4:0]         p_mem [LANE_W];
    logic               byp_q;

`ifndef THETA_BYPASS_EN
    assign byp_q = 1'b0;
`endif

    assign nxt = cnt + 1'b1;

    function automatic logic [4:0] col_parity(input logic [SLICE_W-1:0] a);
        logic [4:0] p;
        p = '0;
        for (int unsigned y = 0; y < 5; y++)
            p = p ^ a[5*y +: 5];
        return p;
    endfunction

    // pz: parity of this slice, pm: parity of the previous slice (z-1 mod LANE_W)
    function automatic logic [SLICE_W-1:0] mix(input logic [SLICE_W-1:0] a,
                                               input logic [4:0] pz,
                                               input logic [4:0] pm,
                                               input logic byp);
        logic [4:0]         d;
        logic [SLICE_W-1:0] r;
        for (int unsigned x = 0; x < 5; x++)
            d[x] = pz[(x + 4) % 5] ^ pm[(x + 1) % 5];
        r = a;
        if (!byp)
            for (int unsigned y = 0; y < 5; y++)
                r[5*y +: 5] = a[5*y +: 5] ^ d;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        a_mem[0] <= s_data;
                        p_mem[0] <= col_parity(s_data);
                        cnt      <= CW'(1);
                        busy     <= 1'b1;
                        state    <= LOAD;
`ifdef THETA_BYPASS_EN
                        byp_q    <= bypass;
`endif
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        a_mem[cnt] <= s_data;
                        p_mem[cnt] <= col_parity(s_data);
                        if (cnt == LAST) begin
                            // Slice 0 needs the last slice's parity, taken straight from the incoming beat
                            m_data  <= mix(a_mem[0], p_mem[0], col_parity(s_data), byp_q);
                            m_valid <= 1'b1;
                            m_last  <= 1'b0;
                            s_ready <= 1'b0;
                            cnt     <= '0;
                            state   <= EMIT;
                        end else begin
                            cnt <= nxt;
                        end
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if (cnt == LAST) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                            cnt     <= '0;
                            state   <= IDLE;
                        end else begin
                            m_data <= mix(a_mem[nxt], p_mem[nxt], p_mem[cnt], byp_q);
                            m_last <= (nxt == LAST);
                            cnt    <= nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_theta_slice_engine.sv
// Randomized self-checking bench for theta_slice_engine (LANE_W=4) against a column-parity reference model.
module tb_theta_slice_engine;

    localparam int unsigned LW = 4;
    typedef logic [24:0] slice_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   s_valid = 1'b0;
    logic   s_ready;
    slice_t s_data = '0;
    logic   m_valid;
    logic   m_ready = 1'b0;
    slice_t m_data;
    logic   m_last;
    logic   busy;
`ifdef THETA_BYPASS_EN
    logic   bypass = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    theta_slice_engine #(.LANE_W(LW), .SLICE_W(25)) dut (
`ifdef THETA_BYPASS_EN
        .bypass  (bypass),
`endif
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: column parities per slice, then the theta mix with wrap-around on z
    function automatic void model(input slice_t a[LW], input bit byp, output slice_t o[LW]);
        logic [4:0] p [LW];
        for (int z = 0; z < LW; z++) begin
            p[z] = '0;
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    p[z][x] = p[z][x] ^ a[z][5*y+x];
        end
        for (int z = 0; z < LW; z++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    o[z][5*y+x] = byp ? a[z][5*y+x]
                                      : a[z][5*y+x] ^ p[z][(x+4)%5] ^ p[(z+LW-1)%LW][(x+1)%5];
    endfunction

    task automatic send_beats(input slice_t d[LW], input int n, input bit byp, input bit gaps);
        for (int z = 0; z < n; z++) begin
            int w = 0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            while (!s_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!s_ready) check("s_ready_wait", 32'(s_ready), 32'd1);
            check("m_valid_load", 32'(m_valid), 32'd0);
            s_valid = 1'b1;
            s_data  = d[z];
`ifdef THETA_BYPASS_EN
            bypass  = (z == 0) ? byp : 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = 25'($urandom);
        end
    endtask

    task automatic recv_state(input slice_t e[LW], input int mode);
        int     k = 0;
        int     cyc = 0;
        int     ph = 0;
        bit     stalled = 0;
        bit     rdy;
        slice_t pd = '0;
        logic   pl = 1'b0;
        check("lat_m_valid", 32'(m_valid), 32'd1);
        check("emit_s_ready", 32'(s_ready), 32'd0);
        check("emit_busy", 32'(busy), 32'd1);
        while (k < LW && cyc < 200) begin
            if (stalled) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(pd));
                check("stall_last", 32'(m_last), 32'(pl));
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (ph % 3 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            ph++;
            m_ready = rdy;
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 25'($urandom);
            if (m_valid && rdy) begin
                check($sformatf("data%0d", k), 32'(m_data), 32'(e[k]));
                check($sformatf("last%0d", k), 32'(m_last), 32'(k == LW - 1));
                k++;
            end
            stalled = m_valid && !rdy;
            pd = m_data;
            pl = m_last;
            @(negedge clk);
            cyc++;
        end
        if (k < LW) check("emit_timeout", 32'(k), 32'(LW));
        m_ready = 1'b0;
        s_valid = 1'b0;
        check("done_m_valid", 32'(m_valid), 32'd0);
        check("done_s_ready", 32'(s_ready), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_case(input slice_t d[LW], input slice_t e[LW], input bit byp,
                            input int mode, input bit gaps);
        send_beats(d, LW, byp, gaps);
        recv_state(e, mode);
    endtask

    task automatic run_random(input int mode, input bit gaps, input bit byp);
        slice_t d[LW];
        slice_t e[LW];
        for (int z = 0; z < LW; z++) d[z] = 25'($urandom);
        model(d, byp, e);
        run_case(d, e, byp, mode, gaps);
    endtask

    initial begin
        slice_t d[LW];
        slice_t e[LW];
        bit     rb;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        d = '{25'h0000001, 25'h0, 25'h0, 25'h0};
        e = '{25'h0210843, 25'h1084210, 25'h0, 25'h0};
        run_case(d, e, 1'b0, 0, 1'b0);

        d = '{25'h0, 25'h0, 25'h0, 25'h0000001};
        e = '{25'h1084210, 25'h0, 25'h0, 25'h0210843};
        run_case(d, e, 1'b0, 0, 1'b0);

        d = '{25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF};
        e = '{25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF};
        run_case(d, e, 1'b0, 1, 1'b0);

        for (int i = 0; i < 20; i++) run_random(i % 3, i[0], 1'b0);

        // Abort a load after two beats, then a clean load must be unaffected
        for (int z = 0; z < LW; z++) d[z] = 25'($urandom);
        send_beats(d, 2, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_load_busy", 32'(busy), 32'd0);
        check("abort_load_s_ready", 32'(s_ready), 32'd1);
        check("abort_load_m_valid", 32'(m_valid), 32'd0);
        run_random(0, 1'b0, 1'b0);

        // Abort mid-emit after one output handshake
        for (int z = 0; z < LW; z++) d[z] = 25'($urandom);
        send_beats(d, LW, 1'b0, 1'b0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_emit_m_valid", 32'(m_valid), 32'd0);
        check("abort_emit_busy", 32'(busy), 32'd0);
        check("abort_emit_s_ready", 32'(s_ready), 32'd1);
        run_random(2, 1'b1, 1'b0);

`ifdef THETA_BYPASS_EN
        d = '{25'h0000001, 25'h0, 25'h0, 25'h0};
        e = '{25'h0000001, 25'h0, 25'h0, 25'h0};
        run_case(d, e, 1'b1, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rb = 1'($urandom_range(0, 1));
            run_random(i % 3, 1'b1, rb);
        end
`else
        rb = 1'b0;
        run_random(1, 1'b1, rb);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
